dual_port_data_memory: RTL and testbench
========================================

Name: dual_port_data_memory

Overview:
Parametrised true-dual-port data memory for the CPU core. Port 1 serves the CPU load/store unit; port 2 serves the debugger. Adds byte-lane write strobes, configurable read latency, deterministic write-collision arbitration with a collision counter, and an optional zero-fill state machine that runs after reset. Sits between the CPU memory stage or debug bridge and the on-chip RAM.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
READ_LATENCY, 1, read latency in cycles from accepted request to data; legal values 1 or 2
PRIORITY, 0, winning port on overlapping-lane write collision; 0 = port 1, 1 = port 2
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = no fill
CNT_W, 16, collision counter width

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  reset; asynchronous, active-high
i_en1  in  1  port 1 request valid
i_write1  in  1  port 1 write (1) / read (0)
i_be1  in  DATA_W/8  port 1 byte-lane write enables
i_address1  in  ADDR_W  port 1 word address
i_data1  in  DATA_W  port 1 write data
o_data1  out  DATA_W  port 1 read data
o_valid1  out  1  port 1 read data valid, one-cycle pulse
i_en2, i_write2, i_be2, i_address2, i_data2  in  as port 1  debugger port request
o_data2  out  DATA_W  port 2 read data
o_valid2  out  1  port 2 read data valid, one-cycle pulse
o_ready  out  1  memory accepts requests
o_collision  out  1  one-cycle pulse on an overlapping-lane write collision
o_collision_count  out  CNT_W  saturating collision count

Behaviour:
- Reset (async, active-high): o_data1/2 = 0, o_valid1/2 = 0, o_ready = 0, o_collision = 0, o_collision_count = 0. All read pipeline stages are flushed. Array contents are untouched by reset itself.
- FSM states:
  - CLEAR: entered on reset release when CLEAR_ON_RESET = 1. Address counter runs 0..DEPTH-1, one word written to 0 per cycle. o_ready = 0. After address DEPTH-1 is written, go to RUN.
  - RUN: o_ready = 1. Entered directly on reset release when CLEAR_ON_RESET = 0.
  - o_ready rises on the first cycle the FSM is in RUN. Reset asserted during CLEAR restarts the fill from address 0.
- Request accepted: when i_enN && o_ready at a rising edge. Requests made while o_ready = 0 are dropped: no write, no valid.
- Reads: read-first. A read returns array contents as they were before any write performed in the same edge, on either port.
  - Read accepted at edge N gives o_dataN and a one-cycle o_validN pulse after edge N+READ_LATENCY-1 (latency 1: visible during the cycle after acceptance).
  - o_dataN holds its last value when o_validN = 0.
  - Reads are fully pipelined: one read per port per cycle.
- Writes: only lanes with i_beN[k] = 1 are updated (lane k = bits 8k+7..8k). be = 0 is a no-op; no valid is produced.
- Simultaneous writes, same address:
  - Lanes enabled by only one port take that port's data.
  - Lanes enabled by both ports take the PRIORITY port's data.
  - o_collision pulses only when at least one lane overlaps. o_collision_count increments once per such edge and saturates at 2**CNT_W-1.
- Simultaneous writes to different addresses: both are performed.
- Write plus read, same address, same edge: the reader gets the old data (read-first).
- All address values are in range, because DEPTH = 2**ADDR_W.
- READ_LATENCY outside {1, 2}: elaboration error.

Decomposition:
- Shared package: FSM state encoding (ST_CLEAR, ST_RUN), the legal READ_LATENCY values, and the PRIORITY encodings PRI_PORT1/PRI_PORT2.
- One natural sub-module, data_memory_read_pipe: a READ_LATENCY-deep data+valid shift stage with reset, instantiated once per port.
- Lane merge, collision detection, counter and clear FSM stay in the top module.

Test Plan:
- Defaults, release i_rst -> o_ready low for exactly 1024 cycles, then high. Port 1 read of 0x3FF -> o_data1 = 0x00000000, o_valid1 pulses one cycle later.
- Port 1 writes 0xDEADBEEF, be = 4'b1111, to 0x010; next cycle port 2 reads 0x010 -> o_data2 = 0xDEADBEEF. Same test with READ_LATENCY = 2 -> o_valid2 arrives one cycle later.
- Port 1 writes 0x11223344, be = 4'b0101, to 0x020 (holding 0) -> readback 0x00220044.
- PRIORITY = 0, same edge, address 0x030:
  - Port 1 writes 0xAAAAAAAA with be 1111, port 2 writes 0x55555555 with be 0011 -> readback 0xAAAAAAAA, o_collision pulses, count = 1.
  - Then port 1 writes be 1100 and port 2 writes be 0011, same data -> readback 0xAAAA5555, no collision pulse, count stays 1.
  - Repeat the first case with PRIORITY = 1 -> readback 0xAAAA5555.
- Port 1 writes 0x00000001 to 0x040 (holding 0) while port 2 reads 0x040 on the same edge -> o_data2 = 0x00000000; the next read returns 0x00000001.
- Assert i_rst at fill cycle 500 and release -> o_ready rises after 1024 further cycles and previously written 0x010 reads 0. Also: requests issued while o_ready = 0 produce no valid and no write.

Source files
------------

// File: rtl/dual_port_data_memory_pkg.sv
// dual_port_data_memory_pkg: shared constants for the dual-port data memory
package dual_port_data_memory_pkg;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;
  localparam int PRI_PORT1 = 0;
  localparam int PRI_PORT2 = 1;
endpackage

// File: rtl/dual_port_data_memory_read_pipe.sv
// data_memory_read_pipe: LATENCY-deep read data/valid shift stage
// i_clk/i_rst: clock, async active-high reset; i_valid/i_data: raw array read;
// o_valid/o_data: delayed read, data holds its last value between valid pulses
module data_memory_read_pipe #(
  parameter int DATA_W = 32,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic [LATENCY-1:0] v;
  logic [DATA_W-1:0] d [LATENCY];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= i_valid;
      if (i_valid) d[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign o_valid = v[LATENCY-1];
  assign o_data = d[LATENCY-1];
endmodule

// File: rtl/dual_port_data_memory.sv
// dual_port_data_memory: true dual-port RAM with byte strobes, read latency, collision arbitration, zero-fill
// Port 1 (i_en1..o_valid1): CPU load/store; port 2 (i_en2..o_valid2): debugger.
// o_ready: accepting requests; o_collision/o_collision_count: overlapping-lane write collisions.
module dual_port_data_memory
  import dual_port_data_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int READ_LATENCY = 1,
  parameter int PRIORITY = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en1,
  input  logic                i_write1,
  input  logic [DATA_W/8-1:0] i_be1,
  input  logic [ADDR_W-1:0]   i_address1,
  input  logic [DATA_W-1:0]   i_data1,
  output logic [DATA_W-1:0]   o_data1,
  output logic                o_valid1,
  input  logic                i_en2,
  input  logic                i_write2,
  input  logic [DATA_W/8-1:0] i_be2,
  input  logic [ADDR_W-1:0]   i_address2,
  input  logic [DATA_W-1:0]   i_data2,
  output logic [DATA_W-1:0]   o_data2,
  output logic                o_valid2,
  output logic                o_ready,
  output logic                o_collision,
  output logic [CNT_W-1:0]    o_collision_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W = DATA_W / 8;
  if (READ_LATENCY < READ_LAT_MIN || READ_LATENCY > READ_LAT_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [ADDR_W-1:0] clr_addr;
  logic acc1, acc2, w1, w2, same, overlap, clearing;
  logic [BE_W-1:0] lane_en1, lane_en2;
  assign o_ready = state == ST_RUN;
  assign acc1 = i_en1 && o_ready;
  assign acc2 = i_en2 && o_ready;
  assign w1 = acc1 && i_write1;
  assign w2 = acc2 && i_write2;
  assign same = w1 && w2 && i_address1 == i_address2;
  assign overlap = same && |(i_be1 & i_be2);
  // Both ports write the same word: the losing port is masked off only on the shared lanes.
  assign lane_en1 = (w1 ? i_be1 : '0) & ~((same && PRIORITY == PRI_PORT2) ? i_be2 : '0);
  assign lane_en2 = (w2 ? i_be2 : '0) & ~((same && PRIORITY == PRI_PORT1) ? i_be1 : '0);
  // The array itself is never reset; the fill is held off while reset is asserted.
  assign clearing = CLEAR_ON_RESET != 0 && state == ST_CLEAR && !i_rst;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      state <= (CLEAR_ON_RESET == 0 || clr_addr == ADDR_W'(DEPTH - 1)) ? ST_RUN : ST_CLEAR;
      clr_addr <= clr_addr + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (clearing) mem[clr_addr] <= '0;
    else
      for (int k = 0; k < BE_W; k++) begin
        if (lane_en1[k]) mem[i_address1][8*k +: 8] <= i_data1[8*k +: 8];
        if (lane_en2[k]) mem[i_address2][8*k +: 8] <= i_data2[8*k +: 8];
      end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_collision <= 1'b0;
      o_collision_count <= '0;
    end else begin
      o_collision <= overlap;
      if (overlap && o_collision_count != '1) o_collision_count <= o_collision_count + 1'b1;
    end
  end
  data_memory_read_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(acc1 && !i_write1), .i_data(mem[i_address1]),
    .o_valid(o_valid1), .o_data(o_data1)
  );
  data_memory_read_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(acc2 && !i_write2), .i_data(mem[i_address2]),
    .o_valid(o_valid2), .o_data(o_data2)
  );
endmodule

// File: tb/tb_dual_port_data_memory.sv
// tb_dual_port_data_memory: directed checks on a default instance and a latency-2/port-2-priority instance
module tb_dual_port_data_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b0, write1 = 1'b0, en2 = 1'b0, write2 = 1'b0;
  logic [3:0] be1 = '0, be2 = '0;
  logic [9:0] a1 = '0, a2 = '0;
  logic [31:0] d1 = '0, d2 = '0;
  logic [31:0] q1, q2, qb1, qb2;
  logic v1, v2, vb1, vb2, rdy, rdyb, col, colb;
  logic [15:0] cnt, cntb;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dual_port_data_memory dut (
    .i_clk(clk), .i_rst(rst),
    .i_en1(en1), .i_write1(write1), .i_be1(be1), .i_address1(a1), .i_data1(d1), .o_data1(q1), .o_valid1(v1),
    .i_en2(en2), .i_write2(write2), .i_be2(be2), .i_address2(a2), .i_data2(d2), .o_data2(q2), .o_valid2(v2),
    .o_ready(rdy), .o_collision(col), .o_collision_count(cnt)
  );
  dual_port_data_memory #(.READ_LATENCY(2), .PRIORITY(1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_en1(en1), .i_write1(write1), .i_be1(be1), .i_address1(a1), .i_data1(d1), .o_data1(qb1), .o_valid1(vb1),
    .i_en2(en2), .i_write2(write2), .i_be2(be2), .i_address2(a2), .i_data2(d2), .o_data2(qb2), .o_valid2(vb2),
    .o_ready(rdyb), .o_collision(colb), .o_collision_count(cntb)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    en1 = 1'b0; write1 = 1'b0; be1 = '0;
    en2 = 1'b0; write2 = 1'b0; be2 = '0;
  endtask
  task automatic wait_ready(input string name);
    int cycles = 0;
    while (!rdy && cycles < 2000) begin
      if (cycles == 100) begin
        en1 = 1'b1; write1 = 1'b1; be1 = 4'hF; a1 = 10'h050; d1 = 32'hFFFFFFFF;
        en2 = 1'b1; write2 = 1'b0; a2 = 10'h050;
      end
      tick();
      cycles++;
      if (cycles == 101) begin
        idle();
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b0 || vb1 !== 1'b0) begin
          errors++;
          $display("FAIL %s_drop_valid: v1=%b v2=%b vb1=%b required 0", name, v1, v2, vb1);
        end
      end
    end
    checks++;
    if (cycles != 1024 || rdyb !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_time: cycles=%0d rdyb=%b required 1024,1", name, cycles, rdyb);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({q1, q2, v1, v2, rdy, col, cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: q1=%h q2=%h v1=%b v2=%b rdy=%b col=%b cnt=%0d required all 0", q1, q2, v1, v2, rdy, col, cnt);
    end
    rst = 1'b0;
    wait_ready("fill");
    en1 = 1'b1; a1 = 10'h3FF;
    tick();
    idle();
    checks++;
    if (v1 !== 1'b1 || q1 !== 32'h0 || vb1 !== 1'b0) begin
      errors++;
      $display("FAIL read_3ff_lat1: v1=%b q1=%h vb1=%b required 1,00000000,0", v1, q1, vb1);
    end
    tick();
    checks++;
    if (v1 !== 1'b0 || vb1 !== 1'b1 || qb1 !== 32'h0) begin
      errors++;
      $display("FAIL read_3ff_lat2: v1=%b vb1=%b qb1=%h required 0,1,00000000", v1, vb1, qb1);
    end
    en2 = 1'b1; a2 = 10'h050;
    tick();
    idle();
    checks++;
    if (v2 !== 1'b1 || q2 !== 32'h0) begin
      errors++;
      $display("FAIL dropped_write: v2=%b q2=%h required 1,00000000", v2, q2);
    end
    tick();
  endtask
  task automatic test_write_read();
    en1 = 1'b1; write1 = 1'b1; be1 = 4'hF; a1 = 10'h010; d1 = 32'hDEADBEEF;
    tick();
    idle();
    en2 = 1'b1; a2 = 10'h010;
    tick();
    idle();
    checks++;
    if (v2 !== 1'b1 || q2 !== 32'hDEADBEEF || vb2 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_lat1: v2=%b q2=%h vb2=%b required 1,deadbeef,0", v2, q2, vb2);
    end
    tick();
    checks++;
    if (vb2 !== 1'b1 || qb2 !== 32'hDEADBEEF || v2 !== 1'b0 || q2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_lat2: vb2=%b qb2=%h v2=%b q2=%h required 1,deadbeef,0,deadbeef", vb2, qb2, v2, q2);
    end
  endtask
  task automatic test_byte_lanes();
    en1 = 1'b1; write1 = 1'b1; be1 = 4'b0101; a1 = 10'h020; d1 = 32'h11223344;
    tick();
    idle();
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL write_no_valid: v1=%b required 0", v1);
    end
    en1 = 1'b1; a1 = 10'h020;
    tick();
    idle();
    checks++;
    if (v1 !== 1'b1 || q1 !== 32'h00220044) begin
      errors++;
      $display("FAIL byte_lanes: v1=%b q1=%h required 1,00220044", v1, q1);
    end
    tick();
  endtask
  task automatic test_collision();
    en1 = 1'b1; write1 = 1'b1; be1 = 4'hF; a1 = 10'h030; d1 = 32'hAAAAAAAA;
    en2 = 1'b1; write2 = 1'b1; be2 = 4'h3; a2 = 10'h030; d2 = 32'h55555555;
    tick();
    idle();
    checks++;
    if (col !== 1'b1 || cnt !== 16'd1 || colb !== 1'b1 || cntb !== 16'd1) begin
      errors++;
      $display("FAIL collision_pulse: col=%b cnt=%0d colb=%b cntb=%0d required 1,1,1,1", col, cnt, colb, cntb);
    end
    en1 = 1'b1; a1 = 10'h030;
    tick();
    idle();
    checks++;
    if (col !== 1'b0 || q1 !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL collision_pri1: col=%b q1=%h required 0,aaaaaaaa", col, q1);
    end
    tick();
    checks++;
    if (vb1 !== 1'b1 || qb1 !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL collision_pri2: vb1=%b qb1=%h required 1,aaaa5555", vb1, qb1);
    end
    en1 = 1'b1; write1 = 1'b1; be1 = 4'hC; a1 = 10'h030; d1 = 32'hAAAAAAAA;
    en2 = 1'b1; write2 = 1'b1; be2 = 4'h3; a2 = 10'h030; d2 = 32'h55555555;
    tick();
    idle();
    checks++;
    if (col !== 1'b0 || cnt !== 16'd1 || colb !== 1'b0 || cntb !== 16'd1) begin
      errors++;
      $display("FAIL disjoint_lanes: col=%b cnt=%0d colb=%b cntb=%0d required 0,1,0,1", col, cnt, colb, cntb);
    end
    en2 = 1'b1; a2 = 10'h030;
    tick();
    idle();
    tick();
    checks++;
    if (q2 !== 32'hAAAA5555 || vb2 !== 1'b1 || qb2 !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL disjoint_readback: q2=%h vb2=%b qb2=%h required aaaa5555,1,aaaa5555", q2, vb2, qb2);
    end
  endtask
  task automatic test_read_first();
    en1 = 1'b1; write1 = 1'b1; be1 = 4'hF; a1 = 10'h040; d1 = 32'h00000001;
    en2 = 1'b1; write2 = 1'b0; a2 = 10'h040;
    tick();
    idle();
    checks++;
    if (v2 !== 1'b1 || q2 !== 32'h0) begin
      errors++;
      $display("FAIL read_first: v2=%b q2=%h required 1,00000000", v2, q2);
    end
    en2 = 1'b1; a2 = 10'h040;
    tick();
    idle();
    checks++;
    if (v2 !== 1'b1 || q2 !== 32'h1 || vb2 !== 1'b1 || qb2 !== 32'h0) begin
      errors++;
      $display("FAIL read_after_write: v2=%b q2=%h vb2=%b qb2=%h required 1,00000001,1,00000000", v2, q2, vb2, qb2);
    end
    tick();
    checks++;
    if (vb2 !== 1'b1 || qb2 !== 32'h1) begin
      errors++;
      $display("FAIL read_after_write_lat2: vb2=%b qb2=%h required 1,00000001", vb2, qb2);
    end
  endtask
  task automatic test_reset_mid_fill();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (500) tick();
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill_ready: rdy=%b required 0", rdy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b0 || cnt !== 16'd0 || cntb !== 16'd0) begin
      errors++;
      $display("FAIL mid_fill_reset: rdy=%b cnt=%0d cntb=%0d required 0,0,0", rdy, cnt, cntb);
    end
    tick();
    rst = 1'b0;
    wait_ready("refill");
    en2 = 1'b1; a2 = 10'h010;
    tick();
    idle();
    checks++;
    if (v2 !== 1'b1 || q2 !== 32'h0) begin
      errors++;
      $display("FAIL refill_cleared: v2=%b q2=%h required 1,00000000", v2, q2);
    end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_collision();
    test_read_first();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
